// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: word width, opcode constants, halt word and the
// instruction-memory server state encoding.
package lc3_pkg;

  localparam int LC3_WORD_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // TRAP x25 (HALT): what the cpu sees when it runs off the loaded image.
  localparam logic [LC3_WORD_W-1:0] LC3_HALT_WORD = 16'hF025;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_RESP
  } imem_state_e;

endpackage

// File: rtl/lc3_imem_server_if.sv
// Fetch handshake between the cpu (master) and the instruction memory (slave).
interface lc3_imem_server_if;
  import lc3_pkg::*;

  logic                  fetch_req;
  logic [LC3_WORD_W-1:0] fetch_addr;
  logic                  fetch_ack;
  logic [LC3_WORD_W-1:0] instr;
  logic                  fault;

  modport master (output fetch_req, fetch_addr, input fetch_ack, instr, fault);
  modport slave  (input fetch_req, fetch_addr, output fetch_ack, instr, fault);

endinterface

// File: rtl/lc3_imem_ram.sv
// Program image storage: one synchronous write port, one asynchronous read port.
module lc3_imem_ram
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [LC3_WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [LC3_WORD_W-1:0] rdata
);

  logic [LC3_WORD_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset; contents past o_prog_len are never returned,
  // so clearing it would only cost a reset fan-out to every storage bit.
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lc3_imem_server.sv
// LC-3 instruction memory: loaded word-by-word from address 0, then serves
// fetch requests over a req/ack handshake with optional wait states.
module lc3_imem_server
  import lc3_pkg::*;
#(
  parameter int                    ADDR_W      = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [LC3_WORD_W-1:0] HALT_WORD   = LC3_HALT_WORD
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ld_start,
  input  logic                  i_ld_valid,
  input  logic [LC3_WORD_W-1:0] i_ld_data,
  input  logic                  i_ld_last,
  output logic                  o_ld_ready,
  output logic                  o_ld_overflow,
  output logic [ADDR_W:0]       o_prog_len,
  lc3_imem_server_if.slave      fetch
);

  localparam int DEPTH = 2**ADDR_W;

  imem_state_e           state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [ADDR_W:0]       len_q;
  logic                  overflow_q;
  logic [LC3_WORD_W-1:0] addr_q;
  logic [LC3_WORD_W-1:0] instr_q;
  logic                  fault_q;
  logic                  resp_go;
  logic                  beat, full, wr_en, accept, in_range;
  logic [LC3_WORD_W-1:0] rd_addr, rdata;

  // len_q is both the image length and the write pointer: every stored beat bumps both.
  assign beat   = i_ld_valid && (state_q == ST_LOAD);
  assign full   = (len_q == (ADDR_W+1)'(DEPTH));
  assign wr_en  = beat && !full;
  assign accept = (state_q == ST_IDLE) && !i_ld_start && fetch.fetch_req;

  // With zero wait states the response is built on the accept edge, before addr_q holds the address.
  assign rd_addr  = (state_q == ST_IDLE) ? fetch.fetch_addr : addr_q;
  assign in_range = ((rd_addr >> ADDR_W) == '0) && ({1'b0, rd_addr[ADDR_W-1:0]} < len_q);

  lc3_imem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk (i_clk),
    .we    (wr_en),
    .waddr (len_q[ADDR_W-1:0]),
    .wdata (i_ld_data),
    .raddr (rd_addr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    resp_go = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_ld_start) begin
          state_d = ST_LOAD;
        end else if (fetch.fetch_req) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            wait_d  = 4'(WAIT_STATES);
          end else begin
            state_d = ST_RESP;
            resp_go = 1'b1;
          end
        end
      end
      ST_LOAD: if (beat && i_ld_last) state_d = ST_IDLE;
      ST_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          state_d = ST_RESP;
          resp_go = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
      addr_q     <= '0;
      instr_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if ((state_q == ST_IDLE) && i_ld_start) begin
        len_q      <= '0;
        overflow_q <= 1'b0;
      end
      if (beat) begin
        if (full) overflow_q <= 1'b1;
        else      len_q      <= len_q + 1'b1;
      end
      if (accept) addr_q <= fetch.fetch_addr;
      if (resp_go) begin
        instr_q <= in_range ? rdata : HALT_WORD;
        fault_q <= !in_range;
      end
    end
  end

  assign o_ld_ready      = (state_q == ST_LOAD);
  assign o_ld_overflow   = overflow_q;
  assign o_prog_len      = len_q;
  assign fetch.fetch_ack = (state_q == ST_RESP);
  assign fetch.instr     = instr_q;
  assign fetch.fault     = fault_q;

endmodule

// File: tb/tb_lc3_imem_server.sv
// Bench for lc3_imem_server: three instances (8-bit/0 waits, 8-bit/3 waits,
// 2-bit/0 waits) share the load port; fetch results go through a scoreboard.
module tb_lc3_imem_server;
  import lc3_pkg::*;

  typedef struct {
    logic [15:0] instr;
    logic        fault;
  } exp_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        ld_start, ld_valid, ld_last;
  logic [15:0] ld_data;

  logic        req   [3];
  logic [15:0] faddr [3];
  logic        ack   [3];
  logic [15:0] instr [3];
  logic        fault [3];
  logic        ready [3];
  logic        ovf   [3];
  logic [8:0]  plen  [3];
  logic [8:0]  plen0, plen1;
  logic [2:0]  plen2;

  lc3_imem_server_if f_if [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign f_if[g].fetch_req  = req[g];
    assign f_if[g].fetch_addr = faddr[g];
    assign ack[g]   = f_if[g].fetch_ack;
    assign instr[g] = f_if[g].instr;
    assign fault[g] = f_if[g].fault;
  end

  assign plen[0] = plen0;
  assign plen[1] = plen1;
  assign plen[2] = {6'd0, plen2};

  lc3_imem_server #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ld_start(ld_start), .i_ld_valid(ld_valid),
    .i_ld_data(ld_data), .i_ld_last(ld_last), .o_ld_ready(ready[0]),
    .o_ld_overflow(ovf[0]), .o_prog_len(plen0), .fetch(f_if[0]));

  lc3_imem_server #(.ADDR_W(8), .WAIT_STATES(3)) u_dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ld_start(ld_start), .i_ld_valid(ld_valid),
    .i_ld_data(ld_data), .i_ld_last(ld_last), .o_ld_ready(ready[1]),
    .o_ld_overflow(ovf[1]), .o_prog_len(plen1), .fetch(f_if[1]));

  lc3_imem_server #(.ADDR_W(2), .WAIT_STATES(0)) u_dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ld_start(ld_start), .i_ld_valid(ld_valid),
    .i_ld_data(ld_data), .i_ld_last(ld_last), .o_ld_ready(ready[2]),
    .o_ld_overflow(ovf[2]), .o_prog_len(plen2), .fetch(f_if[2]));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model of each instance's image.
  int          depth [3] = '{256, 256, 4};
  int          lat   [3] = '{1, 4, 1};
  logic [15:0] m_mem [3][256];
  int          m_len [3];
  logic        m_ovf [3];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input int d, input logic [15:0] a);
    exp_t e;
    if (int'(a) < m_len[d]) begin
      e.instr = m_mem[d][a[7:0]];
      e.fault = 1'b0;
    end else begin
      e.instr = 16'hF025;
      e.fault = 1'b1;
    end
    return e;
  endfunction

  task automatic wait_ack(input int d, input string tag);
    exp_t e;
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge i_clk); n++;
      @(negedge i_clk); seen = ack[d];
    end
    req[d] = 1'b0;
    if (!seen) begin
      check({tag, "_ack_seen"}, 32'(seen), 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check({tag, "_instr"}, instr[d], e.instr);
      check({tag, "_fault"}, fault[d], e.fault);
      check({tag, "_latency"}, n, lat[d]);
      @(negedge i_clk);
      check({tag, "_ack_pulse"}, ack[d], 0);
      check({tag, "_instr_hold"}, instr[d], e.instr);
    end
  endtask

  task automatic fetch(input int d, input logic [15:0] a, input string tag);
    @(negedge i_clk);
    req[d]   = 1'b1;
    faddr[d] = a;
    sb.push_back(predict(d, a));
    wait_ack(d, tag);
  endtask

  // rd >= 0 raises that instance's fetch request on the same cycle as ld_start.
  task automatic load(input logic [15:0] w [8], input int n, input int rd, input logic [15:0] ra);
    @(negedge i_clk);
    ld_start = 1'b1;
    if (rd >= 0) begin
      req[rd]   = 1'b1;
      faddr[rd] = ra;
    end
    @(posedge i_clk);
    for (int d = 0; d < 3; d++) begin m_len[d] = 0; m_ovf[d] = 1'b0; end
    @(negedge i_clk);
    ld_start = 1'b0;
    check("ld_ready_in_load", ready[0], 1);
    check("ovf_cleared_on_start", ovf[2], m_ovf[2]);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = w[i];
      ld_last  = (i == n - 1);
      @(posedge i_clk);
      for (int d = 0; d < 3; d++) begin
        if (m_len[d] < depth[d]) begin
          m_mem[d][m_len[d]] = w[i];
          m_len[d]++;
        end else begin
          m_ovf[d] = 1'b1;
        end
      end
      @(negedge i_clk);
      if (rd >= 0) check("no_ack_during_load", ack[rd], 0);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("ld_ready_drop%0d", d), ready[d], 0);
      check($sformatf("prog_len%0d", d), plen[d], m_len[d]);
      check($sformatf("overflow%0d", d), ovf[d], m_ovf[d]);
    end
  endtask

  logic [15:0] img_a [8] = '{16'h1261, 16'h5262, 16'h967F, 0, 0, 0, 0, 0};
  logic [15:0] img_b [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 0, 0, 0};

  initial begin
    i_rst_n  = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; faddr[d] = '0; m_len[d] = 0; m_ovf[d] = 1'b0;
    end
    repeat (3) @(negedge i_clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_ready", ready[d], 0);
      check("rst_ovf", ovf[d], 0);
      check("rst_plen", plen[d], 0);
      check("rst_ack", ack[d], 0);
      check("rst_instr", instr[d], 0);
      check("rst_fault", fault[d], 0);
    end
    i_rst_n = 1'b1;

    // Three-word image, then in-range and out-of-range fetches on each instance.
    load(img_a, 3, -1, 16'h0);
    fetch(0, 16'h0001, "ws0_addr1");
    fetch(1, 16'h0001, "ws3_addr1");
    fetch(0, 16'h0000, "ws0_addr0");
    fetch(0, 16'h0002, "ws0_addr2");
    fetch(0, 16'h0003, "ws0_addr3_oob");
    fetch(0, 16'h0100, "ws0_upper_oob");
    fetch(1, 16'h0003, "ws3_addr3_oob");
    fetch(2, 16'h0002, "small_addr2");
    fetch(2, 16'h0004, "small_upper_oob");

    // Five beats overflow the four-word instance; the next load clears the flag.
    load(img_b, 5, -1, 16'h0);
    fetch(2, 16'h0003, "small_full_addr3");
    fetch(0, 16'h0004, "ws0_addr4");

    // Load start and fetch together: load wins, fetch is served from the new image.
    load(img_a, 3, 0, 16'h0001);
    sb.push_back(predict(0, 16'h0001));
    wait_ack(0, "prio_fetch");

    // Reset after two beats of a new load.
    @(negedge i_clk);
    ld_start = 1'b1;
    @(negedge i_clk);
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = img_b[i]; ld_last = 1'b0;
      @(negedge i_clk);
    end
    ld_valid = 1'b0;
    i_rst_n  = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      m_len[d] = 0; m_ovf[d] = 1'b0;
      check("midload_rst_ready", ready[d], 0);
      check("midload_rst_plen", plen[d], 0);
      check("midload_rst_instr", instr[d], 0);
      check("midload_rst_fault", fault[d], 0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    fetch(0, 16'h0000, "post_rst_addr0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
